// File: rtl/uart_tx_core.sv
// UART transmit engine: start(0), DATA_WIDTH data bits LSB-first, optional parity, stop(1).
// One bit per clk. TX_OUT and busy are registered from the next state, so the start bit
// and busy=1 appear right after the accepting edge.
module uart_tx_core #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_r;
  logic                  accept_c;
  logic                  tx_nxt;
  logic                  busy_nxt;

  // Next-state, bit counter and next line values
  always_comb begin
    state_nxt   = S_IDLE;
    bit_cnt_nxt = bit_cnt;
    accept_c    = 1'b0;
    tx_nxt      = 1'b1;
    busy_nxt    = 1'b1;

    case (state)
      S_IDLE: begin
        if (DATA_VALID) begin
          state_nxt = S_START;
          accept_c  = 1'b1;
        end
      end
      S_START: begin
        state_nxt   = S_DATA;
        bit_cnt_nxt = '0;
      end
      S_DATA: begin
        if (bit_cnt == CNT_LAST) begin
          bit_cnt_nxt = '0;
          state_nxt   = par_en_r ? S_PARITY : S_STOP;
        end else begin
          bit_cnt_nxt = CNT_W'(bit_cnt + 1'b1);
          state_nxt   = S_DATA;
        end
      end
      S_PARITY: state_nxt = S_STOP;
      S_STOP:   state_nxt = S_IDLE;
      default: begin
        state_nxt   = S_IDLE;
        bit_cnt_nxt = '0;
      end
    endcase

    case (state_nxt)
      S_IDLE:   busy_nxt = 1'b0;
      S_START:  tx_nxt   = 1'b0;
      S_DATA:   tx_nxt   = data_r[bit_cnt_nxt];
      S_PARITY: tx_nxt   = par_r;
      S_STOP:   tx_nxt   = 1'b1;
      default: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

  // State, counter, latched frame and registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      data_r   <= '0;
      par_en_r <= 1'b0;
      par_r    <= 1'b0;
      TX_OUT   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      TX_OUT  <= tx_nxt;
      busy    <= busy_nxt;
      if (accept_c) begin
        data_r   <= P_DATA;
        par_en_r <= PAR_EN;
        par_r    <= (^P_DATA) ^ PAR_TYP;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: line-level behavioural model, per-cycle compare, frame decoder.
module tb_uart_tx_core;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         TX_OUT;
  logic         busy;

  int errors = 0;
  int checks = 0;

  uart_tx_core #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    bit           pe;
    bit           pt;
  } word_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: the line is a queue of frame bits; a word is taken only when idle
  bit    model_known = 1'b0;
  bit    exp_tx      = 1'b1;
  bit    exp_busy    = 1'b0;
  bit    abandon     = 1'b0;
  bit    line_q[$];
  word_t sent_q[$];
  int    accepted    = 0;

  always @(posedge clk) begin
    if (rst) begin
      if (exp_busy && sent_q.size() > 0) void'(sent_q.pop_back());
      line_q.delete();
      exp_tx      = 1'b1;
      exp_busy    = 1'b0;
      abandon     = 1'b1;
      model_known = 1'b1;
    end else if (exp_busy) begin
      if (line_q.size() > 0) exp_tx = line_q.pop_front();
      else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
    end else if (DATA_VALID) begin
      word_t w;
      w.data = P_DATA;
      w.pe   = PAR_EN;
      w.pt   = PAR_TYP;
      sent_q.push_back(w);
      accepted++;
      line_q.delete();
      for (int i = 0; i < int'(W); i++) line_q.push_back(P_DATA[i]);
      if (PAR_EN) line_q.push_back(bit'(($countones(P_DATA) % 2) == 1) ^ PAR_TYP);
      line_q.push_back(1'b1);
      exp_tx   = 1'b0;
      exp_busy = 1'b1;
    end else begin
      exp_tx = 1'b1;
    end
  end

  // Per-cycle compare plus frame capture and decode
  logic        cur[$];
  logic [31:0] fr_q[$];
  int          len_q[$];
  int          idle_run  = 0;
  int          last_gap  = -1;
  logic        prev_busy = 1'b0;
  int          rx_frames = 0;

  always @(negedge clk) begin
    if (model_known) begin
      chk("tx_line", 32'(TX_OUT), 32'(exp_tx));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (abandon) begin
        cur.delete();
        abandon = 1'b0;
      end
      if (busy === 1'b1) begin
        cur.push_back(TX_OUT);
      end else if (cur.size() > 0) begin
        logic [31:0] v;
        int          len;
        v   = '0;
        len = cur.size();
        for (int i = 0; i < len && i < 32; i++) v[i] = cur[i];
        cur.delete();
        fr_q.push_back(v);
        len_q.push_back(len);
        rx_frames++;
        if (sent_q.size() == 0) begin
          chk("rx_unexpected_frame", 32'(len), 32'(0));
        end else begin
          word_t        w;
          logic [W-1:0] rx_data;
          logic [3:0]   errs;
          int           exp_len;
          w       = sent_q.pop_front();
          exp_len = int'(W) + 2 + (w.pe ? 1 : 0);
          rx_data = v[W:1];
          errs    = '0;
          errs[0] = (len != exp_len);
          errs[1] = (v[0] !== 1'b0);
          errs[2] = (len < 1 || len > 32) ? 1'b1 : (v[len-1] !== 1'b1);
          errs[3] = w.pe && (v[W+1] !== (bit'(($countones(rx_data) % 2) == 1) ^ w.pt));
          chk("rx_data", 32'(rx_data), 32'(w.data));
          chk("rx_frame_errors", 32'(errs), 32'(0));
        end
      end
      if (busy !== 1'b1) idle_run++;
      else if (prev_busy !== 1'b1) begin
        last_gap = idle_run;
        idle_run = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40 && busy !== 1'b0; i++) @(negedge clk);
    if (busy !== 1'b0) chk("wait_idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic send(input logic [W-1:0] d, input logic pe, input logic pt);
    wait_idle();
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    @(negedge clk);
    chk("start_latency", {30'd0, busy, TX_OUT}, 32'b10);
    DATA_VALID = 1'b0;
    P_DATA     = W'($urandom);
    PAR_EN     = 1'($urandom);
    PAR_TYP    = 1'($urandom);
  endtask

  task automatic wait_frame(output logic [31:0] fr, output int len);
    int i;
    for (i = 0; i < 60 && fr_q.size() == 0; i++) @(negedge clk);
    if (fr_q.size() == 0) begin
      chk("frame_timeout", 32'(0), 32'(1));
      fr  = '0;
      len = 0;
    end else begin
      fr  = fr_q.pop_front();
      len = len_q.pop_front();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fr;
    int          len;
    int          target;
    int          cyc;

    rst        = 1'b1;
    DATA_VALID = 1'b0;
    P_DATA     = '0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // Reset held 3 cycles, with valid asserted to prove it is ignored
    @(posedge clk);
    DATA_VALID = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_tx", 32'(TX_OUT), 32'(1));
      chk("reset_busy", 32'(busy), 32'(0));
    end
    DATA_VALID = 1'b0;
    rst        = 1'b0;
    repeat (3) @(negedge clk);

    // 0xA5, no parity
    fr_q.delete(); len_q.delete();
    send(8'hA5, 1'b0, 1'b0);
    wait_frame(fr, len);
    chk("a5_nopar_bits", fr, 32'(10'b1101001010));
    chk("a5_nopar_len", 32'(len), 32'(10));

    // 0xA5, even parity -> parity bit 0
    send(8'hA5, 1'b1, 1'b0);
    wait_frame(fr, len);
    chk("a5_even_bits", fr, 32'(11'b10101001010));
    chk("a5_even_len", 32'(len), 32'(11));

    // 0xA5, odd parity -> parity bit 1
    send(8'hA5, 1'b1, 1'b1);
    wait_frame(fr, len);
    chk("a5_odd_bits", fr, 32'(11'b11101001010));
    chk("a5_odd_len", 32'(len), 32'(11));

    // 0x01, even parity -> parity bit 1
    send(8'h01, 1'b1, 1'b0);
    wait_frame(fr, len);
    chk("x01_even_bits", fr, 32'(11'b11000000010));
    chk("x01_even_len", 32'(len), 32'(11));

    // Reset pulsed mid-frame abandons the frame
    send(8'hFF, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_tx", 32'(TX_OUT), 32'(1));
    chk("midreset_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("midreset_no_frame", 32'(fr_q.size()), 32'(0));
    chk("midreset_stays_idle", {30'd0, busy, TX_OUT}, 32'b01);

    // Valid held high; input word changes mid-frame
    fr_q.delete(); len_q.delete();
    wait_idle();
    P_DATA     = 8'hC3;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    DATA_VALID = 1'b1;
    repeat (3) @(negedge clk);
    P_DATA = 8'h3C;
    repeat (9) @(negedge clk);
    DATA_VALID = 1'b0;
    wait_frame(fr, len);
    chk("hold_first_word", 32'(fr[8:1]), 32'h00C3);
    wait_frame(fr, len);
    chk("hold_second_word", 32'(fr[8:1]), 32'h003C);
    chk("hold_gap_cycles", 32'(last_gap), 32'(1));

    // Random traffic: inputs change every cycle, 1000 accepted frames
    wait_idle();
    repeat (2) @(negedge clk);
    rx_frames = 0;
    target    = accepted + 1000;
    cyc       = 0;
    while (accepted < target && cyc < 40000) begin
      DATA_VALID = ($urandom_range(0, 3) != 0);
      P_DATA     = W'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    DATA_VALID = 1'b0;
    chk("random_frames_accepted", 32'(accepted >= target), 32'(1));
    wait_idle();
    repeat (3) @(negedge clk);
    chk("random_frames_received", 32'(rx_frames), 32'(1000));
    chk("random_all_delivered", 32'(sent_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
